// File: rtl/dac_spi_init_seq.sv
// DAC SPI configuration sequencer: pulses the DAC reset, waits for it to settle,
// writes the init table, then serves single-register host reads/writes.
module dac_spi_init_seq #(
  parameter int                      CLK_DIV     = 4,
  parameter int                      RST_CYCLES  = 100,
  parameter int                      WAIT_CYCLES = 1000,
  parameter int                      NUM_INIT    = 4,
  parameter logic [16*NUM_INIT-1:0]  INIT_TABLE  = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       host_req,
  input  logic       host_rw,
  input  logic [4:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       init_done,
  output logic       busy,
  output logic       rst_out,
  output logic       csb,
  output logic       sclk,
  output logic       sdio,
  input  logic       sdo
);

  localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_INIT + 1);
  localparam int ECNT_W  = $clog2(2 * CLK_DIV + 1);

  typedef enum logic [1:0] {S_RST, S_WAIT, S_INIT, S_IDLE} state_t;
  typedef enum logic [1:0] {X_OFF, X_SHIFT, X_GAP} xfer_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                start_pend;

  xfer_t               phase;
  logic [ECNT_W-1:0]   ecnt;
  logic [4:0]          half;
  logic [15:0]         tx;
  logic [7:0]          rx;
  logic                xfer_host;
  logic                xfer_rd;

  logic                eng_ready;
  logic                restart;
  logic                launch;
  logic                launch_host;
  logic [15:0]         launch_word;
  logic [15:0]         init_word;
  logic [15:0]         host_word;

  // The transfer engine may accept a new word on the last gap cycle, so
  // back-to-back transfers see exactly 2*CLK_DIV cycles of csb high.
  assign eng_ready = (phase == X_OFF) ||
                     (phase == X_GAP && ecnt == ECNT_W'(2 * CLK_DIV - 1));
  assign restart   = start || start_pend;
  assign host_word = {host_rw, 2'b00, host_addr, host_rw ? 8'h00 : host_wdata};
  assign sdio      = tx[15];

  always_comb begin
    init_word = '0;
    for (int i = 0; i < NUM_INIT; i++)
      if (idx == IDX_W'(i)) init_word = INIT_TABLE[16*i +: 16];
  end

  // State register
  // NOTE: all sequential state uses non-blocking assignments with the async
  // reset in the sensitivity list, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RST;
      cnt        <= '0;
      idx        <= '0;
      start_pend <= 1'b0;
      rst_out    <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      state      <= state_n;
      start_pend <= (start_pend || start) && (state_n != S_RST);
      rst_out    <= (state_n == S_RST);
      init_done  <= (state_n == S_IDLE);
      if (state_n != state || (state == S_RST && start))
        cnt <= '0;
      else if (state == S_RST || state == S_WAIT)
        cnt <= cnt + CNT_W'(1);
      if (state_n == S_RST || state_n == S_WAIT)
        idx <= '0;
      else if (launch && !launch_host)
        idx <= idx + IDX_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_n unassigned (no latch).
    state_n = state;
    unique case (state)
      S_RST:  if (!start && cnt == CNT_W'(RST_CYCLES - 1)) state_n = S_WAIT;
      S_WAIT: begin
        if (start)                                  state_n = S_RST;
        else if (cnt == CNT_W'(WAIT_CYCLES - 1))    state_n = S_INIT;
      end
      S_INIT: begin
        if (eng_ready) begin
          if (restart)                              state_n = S_RST;
          else if (idx == IDX_W'(NUM_INIT))         state_n = S_IDLE;
        end
      end
      S_IDLE: if (eng_ready && restart)             state_n = S_RST;
    endcase
  end

  // Output logic: transfer launch requests and busy
  always_comb begin
    launch      = 1'b0;
    launch_host = 1'b0;
    launch_word = init_word;
    unique case (state)
      S_RST:  ;
      S_WAIT: launch = !start && cnt == CNT_W'(WAIT_CYCLES - 1);
      S_INIT: launch = eng_ready && !restart && idx != IDX_W'(NUM_INIT);
      S_IDLE: begin
        if (eng_ready && !restart && host_req) begin
          launch      = 1'b1;
          launch_host = 1'b1;
          launch_word = host_word;
        end
      end
    endcase
    busy = !(state == S_IDLE && phase == X_OFF);
  end

  // S_XFER sub-machine: 16-bit SPI shift, mode 0, MSB first, plus the csb gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= X_OFF;
      ecnt       <= '0;
      half       <= '0;
      tx         <= '0;
      rx         <= '0;
      csb        <= 1'b1;
      sclk       <= 1'b0;
      xfer_host  <= 1'b0;
      xfer_rd    <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      unique case (phase)
        X_OFF, X_GAP: begin
          if (launch) begin
            phase     <= X_SHIFT;
            ecnt      <= '0;
            half      <= '0;
            tx        <= launch_word;
            csb       <= 1'b0;
            sclk      <= 1'b0;
            xfer_host <= launch_host;
            xfer_rd   <= launch_host && host_rw;
          end else if (phase == X_GAP) begin
            if (eng_ready) phase <= X_OFF;
            else           ecnt  <= ecnt + ECNT_W'(1);
          end
        end
        X_SHIFT: begin
          if (ecnt == ECNT_W'(CLK_DIV - 1)) begin
            ecnt <= '0;
            half <= half + 5'd1;
            if (!sclk) begin
              sclk <= 1'b1;
              rx   <= {rx[6:0], sdo};
            end else begin
              // Shifting on every fall leaves tx empty, so sdio idles low.
              sclk <= 1'b0;
              tx   <= {tx[14:0], 1'b0};
              if (half == 5'd31) begin
                csb      <= 1'b1;
                phase    <= X_GAP;
                host_ack <= xfer_host;
                if (xfer_host && xfer_rd) host_rdata <= rx;
              end
            end
          end else begin
            ecnt <= ecnt + ECNT_W'(1);
          end
        end
        default: phase <= X_OFF;
      endcase
    end
  end

endmodule

// File: doc/dac_spi_init_seq.md
Name: dac_spi_init_seq

Overview:
SPI configuration sequencer for the dual 16-bit DAC board. After reset it pulses the DAC hardware reset and waits for the DAC to settle. It then writes a parameterised table of DAC registers over the 4-wire SPI port (csb/sclk/sdio/sdo). Once initialisation is complete, it arbitrates single-register host read/write requests onto the same SPI port, so the sweep/datapath logic needs no knowledge of SPI timing.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles (>=1)
RST_CYCLES, 100, clk cycles rst_out held high after reset/start
WAIT_CYCLES, 1000, clk cycles after rst_out falls before first SPI transfer
NUM_INIT, 4, number of init-table entries (>=1)
INIT_TABLE, 64'h0 (16*NUM_INIT bits), entry i = bits [16i+15:16i], formatted as {R/W=0, N=2'b00, addr[4:0], data[7:0]}

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: rerun full DAC reset + init sequence
host_req  in  1  level request; held until host_ack
host_rw  in  1  1=read, 0=write; sampled on acceptance
host_addr  in  5  DAC register address
host_wdata  in  8  write data
host_ack  out  1  one-cycle pulse at end of host transfer
host_rdata  out  8  read data, valid from host_ack until next read completes
init_done  out  1  high once the table is written and the block is idle-capable
busy  out  1  high unless in IDLE with no transfer in progress
rst_out  out  1  DAC hardware reset, active high
csb  out  1  SPI chip select, active low
sclk  out  1  SPI clock, idle low
sdio  out  1  SPI data to DAC
sdo  in  1  SPI data from DAC

Behaviour:
- Reset (async): rst_out=1, csb=1, sclk=0, sdio=0, host_ack=0, host_rdata=0, init_done=0, busy=1; state=S_RST with counter cleared.
- FSM states: S_RST -> S_WAIT -> S_INIT -> S_IDLE, with S_XFER as a shared transfer sub-machine.
- S_RST: rst_out=1 for exactly RST_CYCLES clk cycles after reset deassertion; then rst_out=0 and go to S_WAIT.
- S_WAIT: count WAIT_CYCLES, then go to S_INIT with table index 0.
- S_INIT: issue a write transfer for entry index 0..NUM_INIT-1 in ascending order. After the last transfer plus gap, go to S_IDLE and set init_done=1 on the same cycle.
- S_IDLE: start has priority over host_req in the same cycle. A start pulse clears init_done and sets rst_out=1 on the next cycle, then the sequence begins at S_RST.
- S_IDLE, host_req=1 with no start: latch rw/addr/wdata and launch a transfer with instruction {host_rw, 2'b00, host_addr}. For a write, data = host_wdata; for a read, sdio=0 during the data byte.
- Transfer timing (T0 = cycle csb falls):
  - sdio = bit15 at T0.
  - sclk rises at T0+(2k+1)*CLK_DIV and falls at T0+(2k+2)*CLK_DIV, for k=0..15.
  - sdio updates to the next bit on each falling edge; bits go out MSB first.
  - For reads, sdo is sampled on the rising edges of bits 7..0 into a shift register.
  - csb rises at T0+32*CLK_DIV, i.e. with the last sclk fall.
  - After csb rises, csb stays high for a 2*CLK_DIV gap before another transfer may begin.
- host_ack: one-cycle pulse on the cycle csb rises. host_rdata is updated on the same cycle for reads and is unchanged for writes.
- Requester rules: the requester drops host_req on the cycle after ack. If host_req is still high after the gap, it is treated as a new request.
- host_req outside S_IDLE: ignored and not acked; it is serviced once S_IDLE is reached.
- start during any transfer: latched. The transfer and its gap complete (host_ack still issued), then the restart is applied. A start during S_RST or S_WAIT restarts the counters.
- busy=0 only in S_IDLE when no transfer or gap is active.
- rst mid-transfer: csb goes high and sclk low immediately (async); the aborted transfer is never acked.

Test Plan:
- Power-up with CLK_DIV=2, RST_CYCLES=8, WAIT_CYCLES=16, NUM_INIT=2, INIT_TABLE={16'h0312,16'h0280} -> rst_out high 8 cycles. First csb fall exactly 16 cycles after rst_out falls. An SPI slave model captures 0x0280 then 0x0312, each with csb low 64 cycles and a gap of >=4 cycles. init_done rises after the second gap.
- Host write: host_rw=0, addr=5'h0A, wdata=8'h3C in IDLE -> captured word 0x0A3C, one host_ack, busy high throughout the transfer.
- Host read: addr=5'h1F, slave model drives 0xA5 on sdo -> instruction byte 0x9F, sdio=0 during the data byte, host_rdata=8'hA5 on the host_ack cycle.
- host_req asserted during S_WAIT -> no SPI activity until init completes. The host transfer is the first after the last table entry; exactly one ack.
- start pulsed mid host transfer -> transfer completes and is acked; init_done=0; rst_out high 8 cycles; table rewritten.
- rst asserted at bit 7 of a transfer -> csb=1, sclk=0, rst_out=1 in the same cycle. No host_ack. After release, the sequence repeats from S_RST.
